// File: rtl/irq_pkg.sv
// Shared types, constants and vector helper for the interrupt controller.
// Optional feature macro: INTC_NESTING_EN (see irq_ctrl.sv).
package irq_pkg;

  localparam int unsigned NUM_IRQ = 8;

  typedef logic [2:0] irq_id_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERVICE
  } irq_state_e;

  // Vector address of a line; arithmetic wraps at 32 bits.
  function automatic logic [31:0] irq_vec_f(input logic [31:0] base,
                                            input logic [31:0] stride,
                                            input irq_id_t     id);
    return base + stride * {29'd0, id};
  endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// Request/acknowledge/EOI handshake between the interrupt controller and
// the core.
//   irq_req  : controller -> core, request pending
//   irq_id   : controller -> core, id of requested line (stable in request)
//   irq_vec  : controller -> core, vector address of irq_id
//   irq_ack  : core -> controller, request accepted
//   eoi      : core -> controller, one-cycle end-of-interrupt pulse
// master = controller side, slave = core side.
interface irq_ctrl_if;
  import irq_pkg::*;

  logic        irq_req;
  irq_id_t     irq_id;
  logic [31:0] irq_vec;
  logic        irq_ack;
  logic        eoi;

  modport master (output irq_req, irq_id, irq_vec, input irq_ack, eoi);
  modport slave  (input irq_req, irq_id, irq_vec, output irq_ack, eoi);

endinterface

// File: rtl/irq_ctrl_pri_enc8.sv
// pri_enc8: combinational 8->3 highest-set-bit encoder.
//   vec_i   : input vector
//   id_o    : index of highest set bit (0 when vec_i is zero)
//   valid_o : vec_i has at least one bit set
module pri_enc8
  import irq_pkg::*;
(
  input  logic [7:0] vec_i,
  output irq_id_t    id_o,
  output logic       valid_o
);

  // Ascending scan: the last (highest) set bit overwrites earlier ones.
  always_comb begin
    id_o    = '0;
    valid_o = |vec_i;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (vec_i[i]) id_o = irq_id_t'(i);
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: eight-line interrupt controller. Rising edges on irq_in latch
// pending bits; the highest unmasked pending line is offered to the core
// through a req/ack handshake when int_en is set, and tracked in
// in_service until EOI.
//   clk, rstN  : clock, synchronous active-low reset
//   irq_in     : level request lines, bit 7 highest priority
//   int_en     : global interrupt enable
//   mask       : per-line mask, 1 = blocked for new arbitration
//   bus        : handshake (irq_req/irq_id/irq_vec out, irq_ack/eoi in)
//   pending    : latched, not-yet-acknowledged events
//   in_service : acknowledged, not-yet-EOI'd interrupts
// Define INTC_NESTING_EN to let a higher-priority candidate preempt while
// in service.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
  parameter logic [31:0] VEC_STRIDE = 32'd4
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic [7:0]        irq_in,
  input  logic              int_en,
  input  logic [7:0]        mask,
  irq_ctrl_if.master        bus,
  output logic [7:0]        pending,
  output logic [7:0]        in_service
);

  irq_state_e state_q, state_d;
  irq_id_t    id_q, id_d;
  logic [7:0] prev_q;
  logic [7:0] pending_q, pending_d;
  logic [7:0] isr_q, isr_d;

  logic [7:0] cand;
  irq_id_t    cand_id, isr_id;
  logic       cand_vld, isr_vld;
  logic       ack_hit;

  assign cand    = pending_q & ~mask;
  assign ack_hit = (state_q == REQ) && bus.irq_ack;

  pri_enc8 u_cand_enc (.vec_i(cand),  .id_o(cand_id), .valid_o(cand_vld));
  pri_enc8 u_isr_enc  (.vec_i(isr_q), .id_o(isr_id),  .valid_o(isr_vld));

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    pending_d = pending_q;
    isr_d     = isr_q;

    if (ack_hit) begin
      pending_d[id_q] = 1'b0;
      isr_d[id_q]     = 1'b1;
    end
    if (bus.eoi && isr_vld) isr_d[isr_id] = 1'b0;
    // New edges are OR'd in after the ack clear so a same-cycle edge wins.
    pending_d = pending_d | (irq_in & ~prev_q);

    unique case (state_q)
      IDLE: begin
        if (int_en && cand_vld) begin
          state_d = REQ;
          id_d    = cand_id;
        end
      end
      REQ: begin
        if (bus.irq_ack) begin
          state_d = SERVICE;
        end else if (!int_en || mask[id_q]) begin
          // Withdrawal returns to SERVICE when an older interrupt is still
          // being handled (nested case), otherwise to IDLE.
          state_d = (isr_d != '0) ? SERVICE : IDLE;
        end
      end
      SERVICE: begin
        if (isr_d == '0) begin
          state_d = IDLE;
        end
`ifdef INTC_NESTING_EN
        else if (int_en && cand_vld && (cand_id > isr_id)) begin
          state_d = REQ;
          id_d    = cand_id;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q   <= IDLE;
      id_q      <= '0;
      prev_q    <= '1;
      pending_q <= '0;
      isr_q     <= '0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      prev_q    <= irq_in;
      pending_q <= pending_d;
      isr_q     <= isr_d;
    end
  end

  assign bus.irq_req = (state_q == REQ);
  assign bus.irq_id  = id_q;
  assign bus.irq_vec = irq_vec_f(VEC_BASE, VEC_STRIDE, id_q);
  assign pending     = pending_q;
  assign in_service  = isr_q;

endmodule

// File: tb/tb_irq_ctrl.sv
module tb_irq_ctrl;
  import irq_pkg::*;

  logic       clk = 1'b0;
  logic       rstN;
  logic [7:0] irq_in;
  logic       int_en;
  logic [7:0] mask;
  logic [7:0] pending;
  logic [7:0] in_service;

  irq_ctrl_if bus ();

  irq_ctrl #(.VEC_BASE(32'h0000_0100), .VEC_STRIDE(32'd4)) u_dut (
    .clk        (clk),
    .rstN       (rstN),
    .irq_in     (irq_in),
    .int_en     (int_en),
    .mask       (mask),
    .bus        (bus),
    .pending    (pending),
    .in_service (in_service)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0] m_pend, m_isr, m_prev;
  logic       m_req;
  logic [2:0] m_id;

  function automatic int hi(input logic [7:0] v);
    int r = -1;
    for (int i = 0; i < 8; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock: predict from current inputs, then compare all outputs.
  task automatic tick();
    logic [7:0] n_pend, n_isr, cand;
    logic       n_req;
    logic [2:0] n_id;
    int         hc, hi_isr;
    if (!rstN) begin
      n_pend = '0; n_isr = '0; n_req = 1'b0; n_id = '0;
      m_prev = '1;
    end else begin
      n_pend = m_pend; n_isr = m_isr; n_req = m_req; n_id = m_id;
      cand   = m_pend & ~mask;
      hc     = hi(cand);
      hi_isr = hi(m_isr);
      if (m_req && bus.irq_ack) begin
        n_pend[m_id] = 1'b0;
        n_isr[m_id]  = 1'b1;
      end
      if (bus.eoi && hi_isr >= 0) n_isr[hi_isr] = 1'b0;
      n_pend = n_pend | (irq_in & ~m_prev);
      if (m_req) begin
        if (bus.irq_ack || !int_en || mask[m_id]) n_req = 1'b0;
      end else if (m_isr == 8'h00) begin
        if (int_en && hc >= 0) begin
          n_req = 1'b1;
          n_id  = 3'(hc);
        end
      end else begin
`ifdef INTC_NESTING_EN
        if (n_isr != 8'h00 && int_en && hc > hi_isr) begin
          n_req = 1'b1;
          n_id  = 3'(hc);
        end
`endif
      end
      m_prev = irq_in;
    end
    @(posedge clk);
    #1;
    m_pend = n_pend; m_isr = n_isr; m_req = n_req; m_id = n_id;
    check("irq_req",    {31'd0, bus.irq_req}, {31'd0, m_req});
    check("irq_id",     {29'd0, bus.irq_id},  {29'd0, m_id});
    check("irq_vec",    bus.irq_vec, 32'h100 + 32'(m_id) * 32'd4);
    check("pending",    {24'd0, pending},    {24'd0, m_pend});
    check("in_service", {24'd0, in_service}, {24'd0, m_isr});
  endtask

  task automatic pulse_ack();
    bus.irq_ack = 1'b1; tick(); bus.irq_ack = 1'b0;
  endtask

  task automatic pulse_eoi();
    bus.eoi = 1'b1; tick(); bus.eoi = 1'b0;
  endtask

  initial begin
    m_pend = '0; m_isr = '0; m_prev = '1; m_req = 1'b0; m_id = '0;
    rstN = 1'b0; irq_in = '0; int_en = 1'b1; mask = '0;
    bus.irq_ack = 1'b0; bus.eoi = 1'b0;
    #1;
    tick(); tick();
    check("rst_req", {31'd0, bus.irq_req}, 32'd0);
    check("rst_vec", bus.irq_vec, 32'h100);
    check("rst_pend", {24'd0, pending}, 32'd0);
    rstN = 1'b1;
    tick();

    // Single request on line 5
    irq_in = 8'h20; tick(); tick();
    check("t1_req", {31'd0, bus.irq_req}, 32'd1);
    check("t1_id",  {29'd0, bus.irq_id}, 32'd5);
    check("t1_vec", bus.irq_vec, 32'h114);
    pulse_ack();
    check("t1_pend", {24'd0, pending}, 32'h00);
    check("t1_isr",  {24'd0, in_service}, 32'h20);
    pulse_eoi();
    check("t1_isr_clr", {24'd0, in_service}, 32'h00);
    irq_in = 8'h00; tick();

    // Simultaneous lines 2 and 6
    irq_in = 8'h44; tick(); tick();
    check("t2_first", {29'd0, bus.irq_id}, 32'd6);
    pulse_ack(); pulse_eoi(); tick();
    check("t2_second_req", {31'd0, bus.irq_req}, 32'd1);
    check("t2_second", {29'd0, bus.irq_id}, 32'd2);
    pulse_ack(); pulse_eoi();
    irq_in = 8'h00; tick();

    // Masked line 3
    mask = 8'h08; irq_in = 8'h08; tick(); tick();
    check("t3_pend", {24'd0, pending}, 32'h08);
    check("t3_noreq", {31'd0, bus.irq_req}, 32'd0);
    mask = 8'h00; tick();
    check("t3_id", {29'd0, bus.irq_id}, 32'd3);
    pulse_ack(); pulse_eoi();
    irq_in = 8'h00; tick();

    // int_en withdrawn during request for line 4
    irq_in = 8'h10; tick(); tick();
    check("t4_id", {29'd0, bus.irq_id}, 32'd4);
    int_en = 1'b0; tick();
    check("t4_drop", {31'd0, bus.irq_req}, 32'd0);
    check("t4_pend", {24'd0, pending}, 32'h10);
    int_en = 1'b1; tick();
    check("t4_reissue", {31'd0, bus.irq_req}, 32'd1);
    pulse_ack(); pulse_eoi();
    irq_in = 8'h00; tick();

    // Higher-priority line 7 while line 1 in service
    irq_in = 8'h02; tick(); tick();
    pulse_ack();
    irq_in = 8'h82; tick(); tick();
`ifdef INTC_NESTING_EN
    check("t5_nest_id", {29'd0, bus.irq_id}, 32'd7);
    pulse_ack();
    check("t5_isr2", {24'd0, in_service}, 32'h82);
    pulse_eoi();
    check("t5_eoi7", {24'd0, in_service}, 32'h02);
    pulse_eoi();
    check("t5_eoi1", {24'd0, in_service}, 32'h00);
`else
    check("t5_wait", {31'd0, bus.irq_req}, 32'd0);
    pulse_eoi(); tick();
    check("t5_late_id", {29'd0, bus.irq_id}, 32'd7);
    pulse_ack(); pulse_eoi();
`endif
    irq_in = 8'h00; tick(); tick();

    // Reset during REQ, line held high through release
    irq_in = 8'h01; tick(); tick();
    check("t6_req", {31'd0, bus.irq_req}, 32'd1);
    rstN = 1'b0; tick();
    check("t6_rst_req", {31'd0, bus.irq_req}, 32'd0);
    check("t6_rst_vec", bus.irq_vec, 32'h100);
    rstN = 1'b1; tick(); tick(); tick();
    check("t6_noreq", {31'd0, bus.irq_req}, 32'd0);
    irq_in = 8'h00; tick();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) irq_in = irq_in ^ 8'($urandom & $urandom);
      bus.irq_ack = ($urandom_range(0, 2) == 0);
      bus.eoi     = ($urandom_range(0, 5) == 0);
      int_en      = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) mask = 8'($urandom & $urandom);
      rstN        = ($urandom_range(0, 299) != 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
